imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader: the write-side counterpart of the instruction memory.
- Accepts a length-prefixed byte stream (e.g. from a UART receiver) and assembles big-endian 32-bit instruction words.
- Issues one write strobe per word into the instruction RAM, with byte addresses stepping by 4.
- Holds the CPU in reset until the image is fully loaded.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be a multiple of 4
MAX_WORDS, 256, largest accepted word count; larger headers are rejected

Ports:
clk  input  1  system clock, all state changes on rising edge
clrn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts byte; transfer occurs when in_valid & in_ready at the rising edge
we  output  1  instruction memory write strobe, one cycle per word
wa  output  32  byte address for the write, valid while we=1
wd  output  32  instruction word for the write, valid while we=1
busy  output  1  load in progress
done  output  1  level; last load completed successfully
error  output  1  level; last load rejected
cpu_hold  output  1  holds CPU/PC in reset while 1

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE, in_ready=0, we=0, wa=BASE_ADDR, wd=0, busy=0, done=0, error=0, cpu_hold=1. Internal count, byte index and shift register are cleared.
- Stream format: 2 header bytes give word count N as a big-endian 16-bit value. Then 4N data bytes follow, most-significant byte first per word.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE: in_ready=0. A start pulse moves to LEN_HI, sets busy=1, clears done/error, sets cpu_hold=1 and sets wa=BASE_ADDR.
- LEN_HI / LEN_LO: in_ready=1; each accepted byte advances the state.
  - After LEN_LO is accepted: N=0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> DATA.
- DATA: in_ready=1. Each accepted byte shifts into wd_next = {wd_next[23:0], in_data}. On the 4th accepted byte -> WRITE.
- WRITE: exactly one cycle. we=1, in_ready=0, wa = current address, wd = assembled word. The write strobe appears the cycle after the 4th byte handshake.
  - On exit: address += 4 and remaining count is decremented.
  - Remaining count now 0 -> DONE; otherwise -> DATA.
- DONE: busy=0, done=1, cpu_hold=0, in_ready=0. Stray bytes are not accepted.
- ERR: busy=0, error=1, cpu_hold stays 1, in_ready=0. No writes are issued for a rejected header.
- start behaviour by state:
  - Ignored while busy.
  - In DONE or ERR it restarts as from IDLE; cpu_hold rises in the same edge.
- in_valid low mid-word: the loader waits indefinitely; the partial word is preserved; no timeout.
- Address: 32-bit wrap-around is permitted but unreachable with MAX_WORDS ≤ 2^28. The address after the last write is BASE_ADDR + 4N.
- Reset mid-load: all writes in flight are abandoned, the state returns to IDLE and cpu_hold=1. RAM contents already written are left as is.
- Combinational outputs derive from the state only (Moore). in_ready never depends on in_valid.

Test Plan:
- Reset then start; stream 00 02 3C 01 00 00 34 24 00 50 -> we pulses twice: wa=0x00 wd=0x3C010000, then wa=0x04 wd=0x34240050. After that, done=1, cpu_hold=0, busy=0.
- Header 00 00 -> DONE with no we pulse; cpu_hold drops 1 cycle after the LEN_LO handshake.
- Header 01 01 (N=257) with MAX_WORDS=256 -> error=1, cpu_hold=1, we never asserted; a subsequent start plus a valid 1-word stream recovers to done=1.
- 1-word load with in_valid toggling every other cycle, bytes 0C 00 00 1B -> single write wd=0x0C00001B one cycle after the 4th handshake; in_ready=0 during WRITE.
- Pulse clrn low after 2 of 4 data bytes -> outputs at reset values immediately (asynchronous). A new start with a 1-word stream writes at BASE_ADDR with no leftover bytes.
- start pulsed during DATA -> ignored; load completes normally. start in DONE -> cpu_hold=1 and busy=1 on the next edge.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
// The slave modport is the loader; the master side is the byte source and the RAM.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  we,
        input  wa,
        input  wd
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output we,
        output wa,
        output wd
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction RAM as big-endian words
// and keeps the CPU in reset until the whole image has been written.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN_HI  | waiting for the word-count high byte
// LEN_LO  | waiting for the word-count low byte; decides DONE / ERR / DATA
// DATA    | collecting the 4 bytes of the next word
// WRITE   | one-cycle write strobe of the assembled word
// DONE    | image loaded, CPU released
// ERR     | header rejected, CPU kept in reset
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              start,
    imem_loader_if.slave      bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_hi_q, len_hi_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] wa_q, wa_d;

    logic        rdy;
    logic        accept;
    logic [15:0] len_w;

    assign rdy    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) || (state_q == S_DATA);
    assign accept = rdy && bus.in_valid;
    assign len_w  = {len_hi_q, bus.in_data};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            len_hi_q <= 8'd0;
            cnt_q    <= 16'd0;
            idx_q    <= 2'd0;
            wd_q     <= 32'd0;
            wa_q     <= BASE_ADDR;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wd_q     <= wd_d;
            wa_q     <= wa_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wd_d     = wd_q;
        wa_d     = wa_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    wa_d    = BASE_ADDR;
                    wd_d    = 32'd0;
                    idx_d   = 2'd0;
                    cnt_d   = 16'd0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = bus.in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    cnt_d = len_w;
                    if (len_w == 16'd0)
                        state_d = S_DONE;
                    else if ({16'd0, len_w} > MAX_W)
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    wd_d  = {wd_q[23:0], bus.in_data};
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Down-counter: the word being written now is the last one at count 1.
                wa_d  = wa_q + 32'd4;
                cnt_d = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready = rdy;
    assign bus.we       = (state_q == S_WRITE);
    assign bus.wa       = wa_q;
    assign bus.wd       = wd_q;
    assign busy         = rdy || (state_q == S_WRITE);
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERR);
    assign cpu_hold     = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the main loads
// plus hand sequences for valid gaps, mid-load reset and start handling.
module tb_imem_loader;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    logic start = 1'b0;
    logic busy, done, error, cpu_hold;

    imem_loader_if bus();

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut (
        .clk(clk),
        .clrn(clrn),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .error(error),
        .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        busy;
        logic        done;
        logic        err;
        logic        hold;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_miss = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wr_cnt = 0;
    int          last_hs = -1;
    int          last_wr_cyc = -1;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    logic        last_wr_rdy = 1'b0;

    always @(negedge clk) begin
        #2;
        if (bus.we) begin
            wr_cnt      <= wr_cnt + 1;
            last_wa     <= bus.wa;
            last_wd     <= bus.wd;
            last_wr_cyc <= cyc;
            last_wr_rdy <= bus.in_ready;
        end
        if (bus.in_valid && bus.in_ready)
            last_hs <= cyc;
    end

    function automatic void add(logic st, logic v, logic [7:0] d, logic rdy, logic we,
                                logic [31:0] wa, logic [31:0] wd,
                                logic b, logic dn, logic e, logic h);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.rdy = rdy; r.we = we; r.wa = wa; r.wd = wd;
        r.busy = b; r.done = dn; r.err = e; r.hold = h;
        tbl.push_back(r);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Presents one byte, waits for the handshake, then drops valid for a cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (bus.in_ready) break;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL send_byte: in_ready never rose for byte %h", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end(input string nm);
        for (int i = 0; i < 40; i++) begin
            if (done || error) break;
            @(negedge clk);
        end
        chk({nm, " finished"}, {31'd0, done | error}, 32'd1);
        @(negedge clk);
        #3;
    endtask

    initial begin
        int w0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Two-word load 00 02 3C010000 34240050, stray byte in DONE
        add(1,0,8'h00, 0,0,32'h0,32'h0,        0,0,0,1);
        add(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h02, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h3C, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h01, 1,0,32'h0,32'h3C,       1,0,0,1);
        add(0,1,8'h00, 1,0,32'h0,32'h3C01,     1,0,0,1);
        add(0,1,8'h00, 1,0,32'h0,32'h3C0100,   1,0,0,1);
        add(0,0,8'h00, 0,1,32'h0,32'h3C010000, 1,0,0,1);
        add(0,1,8'h34, 1,0,32'h4,32'h3C010000, 1,0,0,1);
        add(0,1,8'h24, 1,0,32'h4,32'h01000034, 1,0,0,1);
        add(0,1,8'h00, 1,0,32'h4,32'h00003424, 1,0,0,1);
        add(0,1,8'h50, 1,0,32'h4,32'h00342400, 1,0,0,1);
        add(0,0,8'h00, 0,1,32'h4,32'h34240050, 1,0,0,1);
        add(0,0,8'h00, 0,0,32'h8,32'h34240050, 0,1,0,0);
        add(0,1,8'hFF, 0,0,32'h8,32'h34240050, 0,1,0,0);
        add(0,0,8'h00, 0,0,32'h8,32'h34240050, 0,1,0,0);
        // Empty image: header 00 00
        add(1,0,8'h00, 0,0,32'h8,32'h34240050, 0,1,0,0);
        add(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,0,8'h00, 0,0,32'h0,32'h0,        0,1,0,0);
        // N=257 rejected, then recovery with a one-word image
        add(1,0,8'h00, 0,0,32'h0,32'h0,        0,1,0,0);
        add(0,1,8'h01, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h01, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'hAA, 0,0,32'h0,32'h0,        0,0,1,1);
        add(1,0,8'h00, 0,0,32'h0,32'h0,        0,0,1,1);
        add(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h01, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h11, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h22, 1,0,32'h0,32'h11,       1,0,0,1);
        add(0,1,8'h33, 1,0,32'h0,32'h1122,     1,0,0,1);
        add(0,1,8'h44, 1,0,32'h0,32'h112233,   1,0,0,1);
        add(0,0,8'h00, 0,1,32'h0,32'h11223344, 1,0,0,1);
        add(0,0,8'h00, 0,0,32'h4,32'h11223344, 0,1,0,0);
        // N=256 is the largest accepted count
        add(1,0,8'h00, 0,0,32'h4,32'h11223344, 0,1,0,0);
        add(0,1,8'h01, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,1,8'h00, 1,0,32'h0,32'h0,        1,0,0,1);
        add(0,0,8'h00, 1,0,32'h0,32'h0,        1,0,0,1);

        #1;
        chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("reset we",       {31'd0, bus.we},       32'd0);
        chk("reset wa",       bus.wa,                32'h0);
        chk("reset wd",       bus.wd,                32'h0);
        chk("reset flags",    {28'd0, busy, done, error, cpu_hold}, 32'h1);
        repeat (2) @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start        = tbl[i].st;
            bus.in_valid = tbl[i].v;
            bus.in_data  = tbl[i].d;
            #1;
            n_vec++;
            if (bus.in_ready !== tbl[i].rdy || bus.we !== tbl[i].we || bus.wa !== tbl[i].wa ||
                bus.wd !== tbl[i].wd || busy !== tbl[i].busy || done !== tbl[i].done ||
                error !== tbl[i].err || cpu_hold !== tbl[i].hold) begin
                n_miss++;
                $display("FAIL row %0d: got rdy=%b we=%b wa=%h wd=%h busy=%b done=%b err=%b hold=%b expected rdy=%b we=%b wa=%h wd=%h busy=%b done=%b err=%b hold=%b",
                         i, bus.in_ready, bus.we, bus.wa, bus.wd, busy, done, error, cpu_hold,
                         tbl[i].rdy, tbl[i].we, tbl[i].wa, tbl[i].wd,
                         tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].hold);
            end
        end
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;

        // Valid toggling every other cycle, one word 0C00001B
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h0C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h1B);
        wait_end("toggle");
        chk("toggle writes",      wr_cnt - w0,           32'd1);
        chk("toggle wd",          last_wd,               32'h0C00001B);
        chk("toggle wa",          last_wa,               32'h0);
        chk("toggle we latency",  last_wr_cyc,           last_hs + 1);
        chk("toggle rdy in WRITE",{31'd0, last_wr_rdy},  32'd0);
        chk("toggle hold",        {31'd0, cpu_hold},     32'd0);

        // Asynchronous reset after 2 of 4 data bytes
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hAA); send_byte(8'hBB);
        @(negedge clk);
        #3 clrn = 1'b0;
        #1;
        chk("midrst wd",    bus.wd, 32'h0);
        chk("midrst wa",    bus.wa, 32'h0);
        chk("midrst flags", {28'd0, busy, done, error, cpu_hold}, 32'h1);
        chk("midrst ready", {30'd0, bus.in_ready, bus.we}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        wait_end("after reset");
        chk("after reset writes", wr_cnt - w0, 32'd1);
        chk("after reset wd",     last_wd,     32'h12345678);
        chk("after reset wa",     last_wa,     32'h0);

        // start during DATA is ignored; start in DONE restarts
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hDE); send_byte(8'hAD);
        pulse_start();
        chk("start in DATA busy", {31'd0, busy}, 32'd1);
        send_byte(8'hBE); send_byte(8'hEF);
        wait_end("start ignored");
        chk("start ignored writes", wr_cnt - w0, 32'd1);
        chk("start ignored wd",     last_wd,     32'hDEADBEEF);
        chk("done level",           {30'd0, done, cpu_hold}, 32'h2);
        pulse_start();
        #1;
        chk("restart from DONE", {28'd0, busy, done, error, cpu_hold}, 32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
